// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: datapath width and FSM state encodings.
package div_pkg;

    localparam int DIV_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// trial-subtract the divisor and keep the difference only when it does not go negative.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);

    logic [WIDTH:0] r_shift;
    logic [WIDTH:0] diff;

    // The shifted remainder needs one extra bit, otherwise divisors above 2^(WIDTH-1) lose the carry.
    always_comb begin
        r_shift = {r_in, q_in[WIDTH-1]};
        diff    = r_shift - {1'b0, d_in};
        if (!diff[WIDTH]) begin
            r_out = diff[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b1};
        end else begin
            r_out = r_shift[WIDTH-1:0];
            q_out = {q_in[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider_32_bit.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN to add the sgn port and the FIX state for signed operation.
module seq_divider_32_bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic             sgn,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] r_step, q_step;
    logic [WIDTH-1:0] a_mag, b_mag;

`ifdef DIV_SIGNED_EN
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             a_neg, b_neg;

    // Signed operands run through the unsigned core as magnitudes; signs are restored in FIX.
    always_comb begin
        a_neg = sgn & dividend[WIDTH-1];
        b_neg = sgn & divisor[WIDTH-1];
        a_mag = a_neg ? (~dividend + 1'b1) : dividend;
        b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    end
`else
    assign a_mag = dividend;
    assign b_mag = divisor;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in  (r_q),
        .q_in  (q_q),
        .d_in  (d_q),
        .r_out (r_step),
        .q_out (q_step)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        q_d         = q_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
`endif

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        busy_d      = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = RUN;
                        r_d     = '0;
                        q_d     = a_mag;
                        d_d     = b_mag;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
`endif
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                r_d   = r_step;
                q_d   = q_step;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef DIV_SIGNED_EN
                    state_d     = FIX;
`else
                    state_d     = DONE;
                    quotient_d  = q_step;
                    remainder_d = r_step;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
`endif
                end
            end

`ifdef DIV_SIGNED_EN
            // The overflow case needs no special handling: 2^(W-1) negated is itself.
            FIX: begin
                state_d     = DONE;
                quotient_d  = q_neg_q ? (~q_q + 1'b1) : q_q;
                remainder_d = r_neg_q ? (~r_q + 1'b1) : r_q;
                busy_d      = 1'b0;
                done_d      = 1'b1;
            end
`endif

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            q_q         <= q_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
`endif
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_32_bit.sv
// Directed-vector bench for seq_divider_32_bit: table of operations plus hand-written
// sequences for start-while-busy, back-to-back starts and mid-operation reset.
module tb_seq_divider_32_bit;

    localparam int W = 32;
`ifdef DIV_SIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] exp_q;
        logic [31:0] exp_r;
        logic        exp_dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
`ifdef DIV_SIGNED_EN
    logic        sgn;
`endif
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_divider_32_bit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef DIV_SIGNED_EN
        .sgn         (sgn),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Called #1 after an edge; counts further edges until done is seen, bounded.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic apply_stimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output int lat);
        @(negedge clk);
        dividend = a;
        divisor  = b;
`ifdef DIV_SIGNED_EN
        sgn      = s;
`else
        if (s) $display("[TB] note: sgn ignored in unsigned build");
`endif
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        int lat;
        apply_stimulus(v.a, v.b, v.s, lat);
        check_output({tag, " latency"}, 32'(lat), v.exp_dbz ? 32'd0 : 32'(LAT));
        check_output({tag, " quotient"}, quotient, v.exp_q);
        check_output({tag, " remainder"}, remainder, v.exp_r);
        check_output({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.exp_dbz});
        check_output({tag, " busy at done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check_output({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        vec_t vecs[$];
        int   lat;

        vecs.push_back('{32'd100,        32'd7,          1'b0, 32'd14,         32'd2,  1'b0});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,  1'b0});
        vecs.push_back('{32'd3,          32'hFFFF_FFFF,  1'b0, 32'd0,          32'd3,  1'b0});
        vecs.push_back('{32'd5,          32'd0,          1'b0, 32'hFFFF_FFFF,  32'd5,  1'b1});
        vecs.push_back('{32'd1000,       32'd10,         1'b0, 32'd100,        32'd0,  1'b0});
        vecs.push_back('{32'h8000_0000,  32'd3,          1'b0, 32'h2AAA_AAAA,  32'd2,  1'b0});
        vecs.push_back('{32'd7,          32'd9,          1'b0, 32'd0,          32'd7,  1'b0});
`ifdef DIV_SIGNED_EN
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,  1'b0});
        vecs.push_back('{32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,  1'b0});
        vecs.push_back('{32'hFFFF_FFF9,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFF9, 1'b1});
`endif

        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
`ifdef DIV_SIGNED_EN
        sgn      = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check_output("reset quotient", quotient, 32'd0);
        check_output("reset remainder", remainder, 32'd0);
        check_output("reset busy", {31'd0, busy}, 32'd0);
        check_output("reset done", {31'd0, done}, 32'd0);
        check_output("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) run_vector(vecs[i], $sformatf("vec%0d", i));

        // Start held with different operands during RUN must not disturb the first operation.
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 32'd50;
        divisor  = 32'd5;
        repeat (5) @(posedge clk);
        #1;
        check_output("ignore busy flag", {31'd0, busy}, 32'd1);
        start = 1'b0;
        wait_done(lat);
        check_output("ignore latency", 32'(lat), 32'(LAT - 5));
        check_output("ignore quotient", quotient, 32'd14);
        check_output("ignore remainder", remainder, 32'd2);

        // Start in the DONE cycle launches the next operation immediately.
        dividend = 32'd1000;
        divisor  = 32'd10;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("b2b busy", {31'd0, busy}, 32'd1);
        check_output("b2b done low", {31'd0, done}, 32'd0);
        check_output("b2b quotient held", quotient, 32'd14);
        wait_done(lat);
        check_output("b2b latency", 32'(lat), 32'(LAT));
        check_output("b2b quotient", quotient, 32'd100);
        check_output("b2b remainder", remainder, 32'd0);

        // Leave nonzero results, then abort a running operation with reset.
        apply_stimulus(32'd5, 32'd0, 1'b0, lat);
        check_output("pre-reset quotient", quotient, 32'hFFFF_FFFF);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("abort busy", {31'd0, busy}, 32'd0);
        check_output("abort done", {31'd0, done}, 32'd0);
        check_output("abort quotient", quotient, 32'd0);
        check_output("abort remainder", remainder, 32'd0);
        check_output("abort div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_vector('{32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0}, "after abort");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
